// File: rtl/tlp_pkg.sv
// rtl/tlp_pkg.sv - shared types, constants and length decode for the posted-data receive path
package tlp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DW_PER_BEAT = 2;
    localparam int BEAT_SHIFT  = $clog2(DW_PER_BEAT);

    // Header length field: 0 encodes the maximum payload of 1024 DW.
    function automatic logic [10:0] decode_len(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    // DW reserved for a TLP: payload rounded up to a whole number of beats.
    function automatic logic [10:0] need_dw(input logic [9:0] len);
        return (decode_len(len) + 11'd1) & 11'h7FE;
    endfunction

endpackage

// File: rtl/tlp_space_cnt.sv
// rtl/tlp_space_cnt.sv - unreserved FIFO space counter with reserve, release and saturation
module tlp_space_cnt #(
    parameter int C_DEPTH_DW = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          reserve_en,
    input  logic [$clog2(C_DEPTH_DW):0]   reserve_dw,
    input  logic                          rel_valid,
    input  logic [$clog2(C_DEPTH_DW):0]   rel_dw,
    output logic [$clog2(C_DEPTH_DW):0]   free_dw,
    output logic                          err_rel
);

    localparam int W = $clog2(C_DEPTH_DW) + 1;

    logic [W:0] sum;
    logic       over;

    // Next free count; reserve never exceeds free_dw so the subtraction cannot wrap.
    always_comb begin
        sum = {1'b0, free_dw};
        if (reserve_en) begin
            sum = sum - {1'b0, reserve_dw};
        end
        if (rel_valid) begin
            sum = sum + {1'b0, rel_dw};
        end
        over = (sum > (W+1)'(C_DEPTH_DW));
    end

    // Register the free count, clamping at the FIFO depth and flagging over-release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_dw <= W'(C_DEPTH_DW);
            err_rel <= 1'b0;
        end else begin
            free_dw <= over ? W'(C_DEPTH_DW) : sum[W-1:0];
            if (over) begin
                err_rel <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlp_rxpd_ctrl.sv
// rtl/tlp_rxpd_ctrl.sv - posted TLP payload admission and FIFO write control (option: TLP_RXPD_POISON_DROP_EN)
module tlp_rxpd_ctrl
    import tlp_pkg::*;
#(
    parameter int C_DEPTH_DW   = 1024,
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hdr_valid,
    output logic                          hdr_ready,
    input  logic [9:0]                    hdr_len,
    input  logic                          hdr_ep,
    input  logic [C_DATA_WIDTH-1:0]       s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic                          fifo_wr_en,
    output logic [C_DATA_WIDTH-1:0]       fifo_wdata,
    input  logic                          fifo_full,
    input  logic                          rel_valid,
    input  logic [$clog2(C_DEPTH_DW):0]   rel_dw,
    output logic [$clog2(C_DEPTH_DW):0]   free_dw,
    output logic                          busy,
    output logic                          err_len,
    output logic                          err_rel,
    output logic [15:0]                   drop_cnt
);

    localparam int W  = $clog2(C_DEPTH_DW) + 1;
    localparam int CW = (W > 11) ? W : 11;

    state_t      state, state_next;
    logic [9:0]  beat_cnt, beat_cnt_next;
    logic [10:0] need;
    logic        fits;
    logic        reserve_en;
    logic        beat;
    logic        drop_entry;

    assign need       = need_dw(hdr_len);
    assign fits       = (CW'(need) <= CW'(free_dw));
    assign fifo_wdata = s_data;
    assign busy       = (state != ST_IDLE);

    tlp_space_cnt #(
        .C_DEPTH_DW (C_DEPTH_DW)
    ) u_space_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .reserve_en (reserve_en),
        .reserve_dw (W'(need)),
        .rel_valid  (rel_valid),
        .rel_dw     (rel_dw),
        .free_dw    (free_dw),
        .err_rel    (err_rel)
    );

    // State and remaining-beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= 10'd0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // Header admission, beat acceptance and next-state decode.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        hdr_ready     = 1'b0;
        s_ready       = 1'b0;
        fifo_wr_en    = 1'b0;
        reserve_en    = 1'b0;
        beat          = 1'b0;
        drop_entry    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && hdr_valid) begin
`ifdef TLP_RXPD_POISON_DROP_EN
                    if (hdr_ep) begin
                        hdr_ready     = 1'b1;
                        drop_entry    = 1'b1;
                        state_next    = ST_DROP;
                        beat_cnt_next = 10'(need >> BEAT_SHIFT);
                    end else if (fits) begin
                        hdr_ready     = 1'b1;
                        reserve_en    = 1'b1;
                        state_next    = ST_XFER;
                        beat_cnt_next = 10'(need >> BEAT_SHIFT);
                    end
`else
                    if (fits) begin
                        hdr_ready     = 1'b1;
                        reserve_en    = 1'b1;
                        state_next    = ST_XFER;
                        beat_cnt_next = 10'(need >> BEAT_SHIFT);
                    end
`endif
                end
            end
            ST_XFER: begin
                s_ready    = ~fifo_full;
                fifo_wr_en = s_valid & ~fifo_full;
                beat       = s_valid & ~fifo_full;
            end
            ST_DROP: begin
                s_ready = 1'b1;
                beat    = s_valid;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (beat) begin
            beat_cnt_next = beat_cnt - 10'd1;
            if (beat_cnt == 10'd1) begin
                state_next = ST_IDLE;
            end
        end
    end

    // Sticky flag: s_last disagrees with the beat count derived from the header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (beat && (s_last != (beat_cnt == 10'd1))) begin
            err_len <= 1'b1;
        end
    end

`ifdef TLP_RXPD_POISON_DROP_EN
    logic [15:0] drop_cnt_q;

    // Count poisoned TLPs discarded, saturating at the counter maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else if (drop_entry && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_ep;

    assign unused_ep = hdr_ep ^ drop_entry;
    assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_tlp_rxpd_ctrl.sv
// tb/tb_tlp_rxpd_ctrl.sv - directed self-checking bench for tlp_rxpd_ctrl
module tb_tlp_rxpd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [9:0]  hdr_len;
    logic        hdr_ep;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [63:0] fifo_wdata;
    logic        fifo_full;
    logic        rel_valid;
    logic [10:0] rel_dw;
    logic [10:0] free_dw;
    logic        busy;
    logic        err_len;
    logic        err_rel;
    logic [15:0] drop_cnt;

    int n_checks;
    int n_err;
    int wr_count;
    int base;

    tlp_rxpd_ctrl #(
        .C_DEPTH_DW   (1024),
        .C_DATA_WIDTH (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_len    (hdr_len),
        .hdr_ep     (hdr_ep),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .rel_valid  (rel_valid),
        .rel_dw     (rel_dw),
        .free_dw    (free_dw),
        .busy       (busy),
        .err_len    (err_len),
        .err_rel    (err_rel),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && fifo_wr_en) begin
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stream(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = {32'(i), 32'hA5A5_0000 | 32'(i)};
            s_last  = (i == last_idx);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        wr_count  = 0;
        rst_n     = 1'b0;
        hdr_valid = 1'b1;
        hdr_len   = 10'd4;
        hdr_ep    = 1'b0;
        s_data    = 64'd0;
        s_valid   = 1'b1;
        s_last    = 1'b0;
        fifo_full = 1'b0;
        rel_valid = 1'b0;
        rel_dw    = 11'd0;

        // Reset state with live inputs
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_hdr_ready", hdr_ready, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_free", free_dw, 1024);
        check("rst_err_len", err_len, 0);
        check("rst_err_rel", err_rel, 0);
        check("rst_drop", drop_cnt, 0);
        @(negedge clk);

        // hdr_len=4: two beats, 4 DW reserved
        rst_n   = 1'b1;
        s_valid = 1'b0;
        #1;
        check("t1_hdr_ready", hdr_ready, 1);
        base = wr_count;
        step();
        hdr_valid = 1'b0;
        #1;
        check("t1_free", free_dw, 1020);
        check("t1_busy", busy, 1);
        check("t1_hdr_ready_xfer", hdr_ready, 0);
        s_valid = 1'b1;
        s_data  = 64'h1111_2222_3333_4444;
        s_last  = 1'b0;
        #1;
        check("t1_wr1", fifo_wr_en, 1);
        check("t1_wdata", fifo_wdata, 64'h1111_2222_3333_4444);
        step();
        s_data = 64'h5555_6666_7777_8888;
        s_last = 1'b1;
        #1;
        check("t1_wr2", fifo_wr_en, 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check("t1_idle", busy, 0);
        check("t1_writes", wr_count - base, 2);
        check("t1_err_len", err_len, 0);

        // Fill to zero with a 1024 DW TLP, then stall on a 3 DW header with 2 DW free
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        hdr_valid = 1'b1;
        hdr_len   = 10'd0;
        #1;
        check("t2_hdr_max", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        #1;
        check("t2_free0", free_dw, 0);
        base = wr_count;
        stream(512, 511);
        #1;
        check("t2_writes", wr_count - base, 512);
        check("t2_idle", busy, 0);
        check("t2_err_len", err_len, 0);
        rel_valid = 1'b1;
        rel_dw    = 11'd2;
        step();
        rel_valid = 1'b0;
        hdr_valid = 1'b1;
        hdr_len   = 10'd3;
        #1;
        check("t2_free2", free_dw, 2);
        check("t2_stall", hdr_ready, 0);
        step();
        step();
        #1;
        check("t2_stall_hold", hdr_ready, 0);
        check("t2_stall_idle", busy, 0);
        rel_valid = 1'b1;
        rel_dw    = 11'd2;
        #1;
        check("t2_stall_rel", hdr_ready, 0);
        step();
        rel_valid = 1'b0;
        #1;
        check("t2_free4", free_dw, 4);
        check("t2_admit", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        #1;
        check("t2_free_after", free_dw, 0);
        stream(2, 1);
        #1;
        check("t2_done", busy, 0);

        // Same-cycle accept and release, then FIFO back-pressure mid-transfer
        rel_valid = 1'b1;
        rel_dw    = 11'd100;
        step();
        rel_valid = 1'b0;
        #1;
        check("t3_free100", free_dw, 100);
        hdr_valid = 1'b1;
        hdr_len   = 10'd8;
        rel_valid = 1'b1;
        rel_dw    = 11'd16;
        #1;
        check("t3_hdr_ready", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        rel_valid = 1'b0;
        #1;
        check("t3_free108", free_dw, 108);
        base = wr_count;
        stream(2, -1);
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_full_s_ready", s_ready, 0);
            check("t3_full_wr", fifo_wr_en, 0);
            step();
        end
        check("t3_full_writes", wr_count - base, 2);
        check("t3_full_busy", busy, 1);
        fifo_full = 1'b0;
        stream(2, 1);
        #1;
        check("t3_writes", wr_count - base, 4);
        check("t3_idle", busy, 0);

        // Back-to-back header, then a 1-beat TLP without s_last
        hdr_valid = 1'b1;
        hdr_len   = 10'd2;
        #1;
        check("t4_b2b", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        #1;
        check("t4_free106", free_dw, 106);
        check("t4_err_len_pre", err_len, 0);
        stream(1, -1);
        #1;
        check("t4_err_len", err_len, 1);
        check("t4_idle", busy, 0);

        // Release to full depth, then over-release
        rel_valid = 1'b1;
        rel_dw    = 11'd918;
        step();
        rel_valid = 1'b0;
        #1;
        check("t5_free_full", free_dw, 1024);
        check("t5_err_rel_pre", err_rel, 0);
        rel_valid = 1'b1;
        rel_dw    = 11'd8;
        step();
        rel_valid = 1'b0;
        #1;
        check("t5_err_rel", err_rel, 1);
        check("t5_free_sat", free_dw, 1024);

`ifdef TLP_RXPD_POISON_DROP_EN
        // Poisoned TLP: three beats consumed without writes or reservation
        hdr_valid = 1'b1;
        hdr_ep    = 1'b1;
        hdr_len   = 10'd6;
        #1;
        check("t6_hdr_ready", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        hdr_ep    = 1'b0;
        #1;
        check("t6_busy", busy, 1);
        check("t6_free", free_dw, 1024);
        check("t6_drop", drop_cnt, 1);
        base = wr_count;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_last  = (i == 2);
            #1;
            check("t6_s_ready", s_ready, 1);
            check("t6_wr", fifo_wr_en, 0);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check("t6_idle", busy, 0);
        check("t6_writes", wr_count - base, 0);
        check("t6_drop_hold", drop_cnt, 1);
`else
        // Poison bit ignored: normal reserve and write
        hdr_valid = 1'b1;
        hdr_ep    = 1'b1;
        hdr_len   = 10'd2;
        #1;
        check("t6_hdr_ready", hdr_ready, 1);
        step();
        hdr_valid = 1'b0;
        hdr_ep    = 1'b0;
        #1;
        check("t6_free", free_dw, 1022);
        check("t6_drop", drop_cnt, 0);
        base = wr_count;
        stream(1, 0);
        #1;
        check("t6_writes", wr_count - base, 1);
        check("t6_idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tlp_rxpd_ctrl.md
TLP_RXPD_CTRL -- requirements
Module: tlp_rxpd_ctrl

Interface
REQ-001 Parameter C_DEPTH_DW, 1024, capacity of the posted-data FIFO in DW (power of two, 256..4096).
REQ-002 Parameter C_DATA_WIDTH, 64, data beat width (2 DW per beat, fixed).
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 hdr_valid  in  1  posted TLP header available; hdr_ready  out  1  header accepted this cycle.
REQ-006 hdr_len  in  10  payload length in DW; 0 encodes 1024.
REQ-007 hdr_ep  in  1  poisoned (EP) bit of the header.
REQ-008 s_data  in  64, s_valid  in  1, s_last  in  1, s_ready  out  1: payload beat stream.
REQ-009 fifo_wr_en  out  1, fifo_wdata  out  64, fifo_full  in  1: posted-data FIFO write port.
REQ-010 rel_valid  in  1, rel_dw  in  clog2(C_DEPTH_DW)+1: consumer returns rel_dw DW of space.
REQ-011 free_dw  out  clog2(C_DEPTH_DW)+1: unreserved FIFO space in DW.
REQ-012 busy  out  1 (state != IDLE); err_len  out  1 sticky; err_rel  out  1 sticky; drop_cnt  out  16.

Function
REQ-013 FSM states IDLE, XFER, DROP; reserve need = 2*ceil(len/2) DW, len = hdr_len decoded (0 -> 1024).
REQ-014 IDLE: hdr_ready = hdr_valid & (need <= free_dw), combinational; on accept, go to XFER with beat count = need/2.
REQ-015 No partial admission: header stalls (hdr_ready=0) until need <= free_dw; no timeout.
REQ-016 On accept, free_dw decreases by need in the next cycle; space is reserved before any data moves.
REQ-017 XFER: s_ready = ~fifo_full; fifo_wr_en = s_valid & s_ready; fifo_wdata = s_data; zero latency.
REQ-018 Each written beat decrements the beat count; the beat at count==1 returns the FSM to IDLE.
REQ-019 s_last asserted at count!=1, or deasserted at count==1, sets err_len; the FSM still follows the beat count.
REQ-020 rel_valid adds rel_dw to free_dw; same-cycle accept and release give free_dw_next = free_dw - need + rel_dw.
REQ-021 A release that would exceed C_DEPTH_DW saturates free_dw at C_DEPTH_DW and sets err_rel.
REQ-022 hdr_ready and s_ready are 0 outside IDLE and outside XFER/DROP, respectively.
REQ-023 Back-to-back: a new header may be accepted in the cycle after the last beat (IDLE one cycle minimum).

Reset
REQ-024 rst_n low: state=IDLE, free_dw=C_DEPTH_DW, beat count=0, err_len=0, err_rel=0, drop_cnt=0.
REQ-025 Combinational outputs under reset: hdr_ready=0, s_ready=0, fifo_wr_en=0, busy=0.
REQ-026 Reset mid-transfer abandons the TLP with no further writes; recovery of FIFO contents is the system's responsibility.

Configuration
REQ-027 Macro TLP_RXPD_POISON_DROP_EN defined: a header with hdr_ep=1 is accepted regardless of free_dw and enters DROP with no reservation.
REQ-028 DROP: s_ready=1, fifo_wr_en=0, beats counted as in XFER; drop_cnt increments (saturates at 0xFFFF) on entry.
REQ-029 Macro undefined: hdr_ep is ignored, DROP is unreachable, drop_cnt is tied to 0.

Structure
REQ-030 Shared package tlp_pkg holds the FSM state enum, the DW-per-beat constant and the length-decode function (0 -> 1024).
REQ-031 Single module. The space counter (reserve/release/saturate) is a natural sub-module, tlp_space_cnt.

Verification
REQ-032 Reset, hdr_len=4, 2 beats -> hdr_ready=1 in cycle 1, free_dw=1020, two fifo_wr_en pulses, IDLE after beat 2.
REQ-033 free_dw=2, hdr_len=3 -> stall; rel_dw=2 -> free_dw=4, hdr_ready next cycle, free_dw=0.
REQ-034 Same-cycle accept (hdr_len=8) and release rel_dw=16 with free_dw=100 -> free_dw=108.
REQ-035 fifo_full held 5 cycles mid-transfer -> s_ready=0 and no writes for exactly 5 cycles; beat count unchanged.
REQ-036 hdr_len=2 with s_last on beat 2 of 1 -> err_len=1, FSM in IDLE after 1 beat; release of 8 at free_dw=C_DEPTH_DW -> err_rel=1, free_dw unchanged.
REQ-037 TLP_RXPD_POISON_DROP_EN defined, hdr_ep=1, hdr_len=6 -> 3 beats consumed, fifo_wr_en=0, drop_cnt=1, free_dw unchanged.
